psum_writeback: RTL

Drain controller for the corelet output path: pops psum vectors from the OFIFO (`ofifo_rd`/`ofifo_valid`/`ofifo_rdata`) and writes them row by row into the psum SRAM starting at a programmed base address. It is the consumer end of the OFIFO interface and sits between the corelet and the psum memory in the core. An optional accumulate mode does read-modify-write, adding each OFIFO vector to the word already stored.

---
 rtl/psum_writeback_if.sv | 33 +++
 rtl/psum_writeback.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback_if.sv
// OFIFO-consumer and psum-SRAM port bundle for the psum writeback engine.
//   master : writeback side  - drives ofifo_rd and the sram_* command/data,
//                              receives ofifo_valid/ofifo_rdata/sram_rdata.
//   slave  : OFIFO + SRAM side (the opposite directions).
interface psum_writeback_if #(
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned COL     = 8,
  parameter int unsigned ADDR_W  = 11
);

  localparam int unsigned VEC_W = PSUM_BW * COL;

  logic              ofifo_valid;
  logic [VEC_W-1:0]  ofifo_rdata;
  logic              ofifo_rd;

  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [VEC_W-1:0]  sram_wdata;
  logic [VEC_W-1:0]  sram_rdata;

  modport master (
    input  ofifo_valid, ofifo_rdata, sram_rdata,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_wdata
  );

  modport slave (
    output ofifo_valid, ofifo_rdata, sram_rdata,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_wdata
  );

endinterface

// File: rtl/psum_writeback.sv
// psum_writeback: drains psum vectors from the OFIFO into the psum SRAM,
// one row per address starting at a programmed base address.
// Optional accumulate mode (compiled in when PSUM_WB_ACC_EN is defined)
// reads the stored word, adds the OFIFO vector column-wise and writes back.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   one-cycle job request (accepted in IDLE only)
//   base_addr, num_rows     first SRAM address / row count, latched on start
//   acc_i                   accumulate request, latched on start
//   bus (master modport)    OFIFO pop interface + registered SRAM port
//   busy                    high whenever not IDLE
//   done                    one-cycle pulse, coincident with the last write
module psum_writeback #(
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned COL     = 8,
  parameter int unsigned ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic              acc_i,
  psum_writeback_if.master  bus,
  output logic              busy,
  output logic              done
);

  localparam int unsigned VEC_W = PSUM_BW * COL;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

`ifdef PSUM_WB_ACC_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    ACC_RD   = 3'd2,
    ACC_WAIT = 3'd3,
    ACC_WR   = 3'd4,
    DONE     = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    DONE  = 3'd5
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               sram_cen_q, sram_cen_d;
  logic               sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic [VEC_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic               ofifo_rd_c;
  logic               last_row_c;
  logic [ADDR_W-1:0]  cnt_dec_c;

  // Row counter decrement that holds at zero.
  assign last_row_c = (cnt_q <= ONE);
  assign cnt_dec_c  = (cnt_q != '0) ? cnt_q - ONE : cnt_q;

`ifdef PSUM_WB_ACC_EN
  logic [VEC_W-1:0] acc_sum_c;

  // Per-column add; each lane wraps at psum_bw bits.
  always_comb begin
    acc_sum_c = '0;
    for (int unsigned c = 0; c < COL; c++) begin
      acc_sum_c[c*PSUM_BW +: PSUM_BW] = bus.ofifo_rdata[c*PSUM_BW +: PSUM_BW]
                                      + bus.sram_rdata[c*PSUM_BW +: PSUM_BW];
    end
  end
`else
  // Accumulate path not built: these inputs are intentionally ignored.
  logic unused_acc;
  assign unused_acc = ^{acc_i, bus.sram_rdata};
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    sram_cen_d   = 1'b1;
    sram_wen_d   = 1'b1;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    ofifo_rd_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          cnt_d  = num_rows;
          if (num_rows == '0) begin
            state_d = DONE;
          end else begin
            // The chosen path carries the job mode for the rest of the job.
            state_d = DRAIN;
`ifdef PSUM_WB_ACC_EN
            if (acc_i) state_d = ACC_RD;
`endif
          end
        end
      end

      DRAIN: begin
        ofifo_rd_c = bus.ofifo_valid;
        if (bus.ofifo_valid) begin
          sram_cen_d   = 1'b0;
          sram_wen_d   = 1'b0;
          sram_addr_d  = addr_q;
          sram_wdata_d = bus.ofifo_rdata;
          addr_d       = addr_q + ONE;
          cnt_d        = cnt_dec_c;
          if (last_row_c) state_d = DONE;
        end
      end

`ifdef PSUM_WB_ACC_EN
      // Read only once the vector is present, so ACC_WR can pop blindly.
      ACC_RD: begin
        if (bus.ofifo_valid) begin
          sram_cen_d  = 1'b0;
          sram_addr_d = addr_q;
          state_d     = ACC_WAIT;
        end
      end

      ACC_WAIT: begin
        state_d = ACC_WR;
      end

      ACC_WR: begin
        ofifo_rd_c   = 1'b1;
        sram_cen_d   = 1'b0;
        sram_wen_d   = 1'b0;
        sram_addr_d  = addr_q;
        sram_wdata_d = acc_sum_c;
        addr_d       = addr_q + ONE;
        cnt_d        = cnt_dec_c;
        state_d      = last_row_c ? DONE : ACC_RD;
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and SRAM port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      sram_cen_q   <= 1'b1;
      sram_wen_q   <= 1'b1;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      sram_cen_q   <= sram_cen_d;
      sram_wen_q   <= sram_wen_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // Pop is suppressed while reset is asserted so an aborted job takes no extra row.
  assign bus.ofifo_rd   = ofifo_rd_c & ~reset;
  assign bus.sram_cen   = sram_cen_q;
  assign bus.sram_wen   = sram_wen_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
